// File: rtl/conv3x3_mac.sv
// conv3x3_mac: shadow-buffered 3x3 window capture with sequential signed dot-product MAC
module conv3x3_mac #(
  parameter int DW   = 8,
  parameter int KW   = 8,
  parameter int ACCW = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [8:0]       sel,
  input  logic             d_load,
  input  logic             k_load,
  input  logic [DW-1:0]    din,
  input  logic [KW-1:0]    kin,
  output logic [ACCW-1:0]  result,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun,
  output logic             sel_err
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [DW-1:0] sh_d [9];
  logic [KW-1:0] sh_k [9];
  logic [DW-1:0] nsh_d [9];
  logic [KW-1:0] nsh_k [9];
  logic [DW-1:0] act_d [9];
  logic [KW-1:0] act_k [9];
  logic [3:0] t;
  logic [ACCW-1:0] acc;
  logic pending;
  logic onehot, ld, comp, last, commit;
  logic signed [DW+KW-1:0] prod;
  logic [ACCW-1:0] sum;
  // select decode, completion detect and the current tap product
  always_comb begin
    onehot = (sel != '0) && ((sel & (sel - 9'd1)) == '0);
    ld = d_load | k_load;
    comp = d_load & sel[8] & onehot;
    last = (state == RUN) && (t == 4'd8);
    commit = ((state == IDLE) && comp) || (last && (pending || comp));
    prod = $signed(act_d[t]) * $signed(act_k[t]);
    sum = acc + {{(ACCW-DW-KW){prod[DW+KW-1]}}, prod};
  end
  // shadow contents after this edge's writes; commits take these so the tap-8 word is merged in
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      nsh_d[i] = (d_load && onehot && sel[i]) ? din : sh_d[i];
      nsh_k[i] = (k_load && onehot && sel[i]) ? kin : sh_k[i];
    end
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  // next state: enter RUN on completion, leave only when the last tap has no follow-on window
  always_comb begin
    state_nx = (state == IDLE) ? (comp ? RUN : IDLE) :
               (last && !(pending || comp)) ? IDLE : RUN;
  end
  // state-derived outputs
  always_comb begin
    busy = (state == RUN);
  end
  // shadow capture, window commit, accumulation and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) begin
        sh_d[i] <= '0;
        sh_k[i] <= '0;
        act_d[i] <= '0;
        act_k[i] <= '0;
      end
      t <= '0;
      acc <= '0;
      pending <= 1'b0;
      result <= '0;
      out_valid <= 1'b0;
      overrun <= 1'b0;
      sel_err <= 1'b0;
    end else begin
      for (int i = 0; i < 9; i++) begin
        sh_d[i] <= nsh_d[i];
        sh_k[i] <= nsh_k[i];
        if (commit) begin
          act_d[i] <= nsh_d[i];
          act_k[i] <= nsh_k[i];
        end
      end
      sel_err <= sel_err | (ld & ~onehot);
      out_valid <= last;
      if (last) result <= sum;
      if (commit) begin
        acc <= '0;
        t <= '0;
      end else if (state == RUN) begin
        acc <= sum;
        t <= t + 4'd1;
      end
      if (commit) pending <= 1'b0;
      else if ((state == RUN) && comp) pending <= 1'b1;
      if ((state == RUN) && !last && comp && pending) overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_conv3x3_mac.sv
// tb_conv3x3_mac: directed stimulus with a transaction-level dot-product model checked every cycle
module tb_conv3x3_mac;
  logic clk = 0;
  logic rst = 1;
  logic d_load = 0;
  logic k_load = 0;
  logic [8:0] sel = '0;
  logic [7:0] din = '0;
  logic [7:0] kin = '0;
  logic [19:0] result;
  logic out_valid, busy, overrun, sel_err;
  int tests = 0;
  int fails = 0;
  bit chk_en = 0;
  int m_d [9];
  int m_k [9];
  int cyc = 0;
  int run_end = -1;
  bit pend = 0;
  bit e_ovr = 0;
  bit e_serr = 0;
  bit e_valid = 0;
  logic [19:0] e_res = '0;
  logic [19:0] cur_res = '0;
  conv3x3_mac dut (
    .clk(clk), .rst(rst), .sel(sel), .d_load(d_load), .k_load(k_load),
    .din(din), .kin(kin), .result(result), .out_valid(out_valid),
    .busy(busy), .overrun(overrun), .sel_err(sel_err)
  );
  always #5 clk = ~clk;
  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [19:0] dot();
    int s = 0;
    for (int i = 0; i < 9; i++) s += m_d[i] * m_k[i];
    return 20'(s);
  endfunction
  task automatic model_step();
    bit oh, comp;
    cyc++;
    if (rst) begin
      for (int i = 0; i < 9; i++) begin
        m_d[i] = 0;
        m_k[i] = 0;
      end
      run_end = -1;
      pend = 0;
      e_ovr = 0;
      e_serr = 0;
      e_valid = 0;
      e_res = '0;
      cur_res = '0;
      return;
    end
    oh = ($countones(sel) == 1);
    if ((d_load || k_load) && !oh) e_serr = 1;
    for (int i = 0; i < 9; i++) begin
      if (oh && sel[i]) begin
        if (d_load) m_d[i] = int'($signed(din));
        if (k_load) m_k[i] = int'($signed(kin));
      end
    end
    comp = d_load && oh && sel[8];
    e_valid = 0;
    if (run_end == cyc) begin
      e_valid = 1;
      e_res = cur_res;
      if (pend || comp) begin
        cur_res = dot();
        run_end = cyc + 9;
        pend = 0;
      end else run_end = -1;
    end else if (run_end > cyc) begin
      if (comp) begin
        if (pend) e_ovr = 1;
        pend = 1;
      end
    end else if (comp) begin
      cur_res = dot();
      run_end = cyc + 9;
    end
  endtask
  task automatic tick(bit dl, bit kl, logic [8:0] s, logic [7:0] d, logic [7:0] k);
    d_load = dl;
    k_load = kl;
    sel = s;
    din = d;
    kin = k;
    @(posedge clk);
    model_step();
    #1;
  endtask
  task automatic idle(int n);
    repeat (n) tick(0, 0, '0, '0, '0);
  endtask
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", out_valid, e_valid);
      check("busy", busy, run_end > cyc);
      check("result", result, e_res);
      check("overrun", overrun, e_ovr);
      check("sel_err", sel_err, e_serr);
    end
  end
  initial begin
    rst = 1;
    idle(2);
    rst = 0;
    chk_en = 1;
    check("rst_result", result, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    for (int i = 0; i < 9; i++) tick(0, 1, 9'(1 << i), '0, 8'd1);
    for (int i = 0; i < 8; i++) tick(1, 0, 9'(1 << i), 8'(i + 1), '0);
    tick(1, 0, 9'h100, 8'd9, '0);
    idle(11);
    check("t1_sum45", result, 20'd45);
    for (int i = 0; i < 9; i++) tick(1, 1, 9'(1 << i), 8'h80, 8'h7f);
    idle(11);
    check("t2_neg", result, 20'hDC480);
    for (int i = 0; i < 9; i++) tick(1, 1, 9'(1 << i), 8'(i + 1), 8'd1);
    idle(3);
    tick(1, 0, 9'h100, 8'd9, '0);
    idle(20);
    check("t3_no_overrun", overrun, 0);
    check("t3_b2b", result, 20'd45);
    tick(1, 0, 9'h100, 8'd9, '0);
    tick(1, 0, 9'h001, 8'd10, '0);
    tick(1, 0, 9'h100, 8'd9, '0);
    tick(1, 0, 9'h001, 8'd20, '0);
    tick(1, 0, 9'h100, 8'd9, '0);
    idle(20);
    check("t3_overrun", overrun, 1);
    check("t3_newest", result, 20'd64);
    tick(1, 0, 9'b000000011, 8'd55, '0);
    tick(0, 1, 9'h000, '0, 8'd77);
    idle(2);
    check("t4_sel_err", sel_err, 1);
    tick(1, 0, 9'h100, 8'd9, '0);
    idle(11);
    check("t4_unchanged", result, 20'd64);
    check("t4_sticky", sel_err, 1);
    rst = 1;
    idle(1);
    rst = 0;
    check("t5_clr_err", sel_err, 0);
    check("t5_clr_ovr", overrun, 0);
    for (int i = 0; i < 9; i++) tick(1, 1, 9'(1 << i), 8'(i + 1), 8'd1);
    idle(3);
    rst = 1;
    idle(1);
    rst = 0;
    check("t5_busy", busy, 0);
    check("t5_valid", out_valid, 0);
    check("t5_result", result, 0);
    idle(12);
    check("t5_no_strobe", result, 0);
    for (int i = 0; i < 9; i++) tick(1, 1, 9'(1 << i), 8'(i + 1), 8'd1);
    for (int i = 0; i < 8; i++) tick(0, 1, 9'(1 << i), '0, 8'd2);
    idle(3);
    check("t6_inflight", result, 20'd45);
    tick(1, 1, 9'h100, 8'd9, 8'd2);
    idle(11);
    check("t6_next", result, 20'd90);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
